// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and default sizing for the two-master memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int unsigned c_def_addr_w  = 32;
    localparam int unsigned c_def_data_w  = 32;
    localparam int unsigned c_def_timeout = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_wdog.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_wdog
// Brief    : Watchdog counting stalled memory cycles; flags the final allowed one.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_wdog
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = c_def_timeout
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_count;
    logic               w_hit;

    assign w_hit   = (r_count == c_last);
    assign expired = enable && w_hit;

    // Saturates at the last value so the counter never wraps while held.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable && !w_hit) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Arbitrates fetch and load/store masters onto one memory port.
//            Define MEM_ARB_RR_EN for round-robin; default is fixed dm priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = c_def_addr_w,
    parameter int unsigned DATA_W  = c_def_data_w,
    parameter int unsigned TIMEOUT = c_def_timeout
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_wstrb,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                resp_err,
    output logic                busy
);

    localparam int unsigned c_strb_w = DATA_W / 8;

    state_t              r_state;
    state_t              w_next;
    owner_t              r_owner;
    owner_t              w_win;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [c_strb_w-1:0] r_wstrb;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic                w_any_req;
    logic                w_grant;
    logic                w_expired;

    assign w_any_req = if_req || dm_req;
    assign w_grant   = (r_state == IDLE) && w_any_req;

`ifdef MEM_ARB_RR_EN
    owner_t r_last;

    // Reset value OWN_IF makes dm the first winner of a tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= OWN_IF;
        end else if (w_grant) begin
            r_last <= w_win;
        end
    end

    assign w_win = (dm_req && (!if_req || (r_last == OWN_IF))) ? OWN_DM : OWN_IF;
`else
    assign w_win = dm_req ? OWN_DM : OWN_IF;
`endif

    mem_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (r_state == IDLE),
        .enable  ((r_state == BUSY) && !mem_ready),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_any_req) w_next = BUSY;
            BUSY:    if (mem_ready || w_expired) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // A fetch is always a plain read: write controls are forced low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= OWN_IF;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_grant) begin
            r_owner <= w_win;
            r_addr  <= (w_win == OWN_DM) ? dm_addr : if_addr;
            r_we    <= (w_win == OWN_DM) && dm_we;
            r_wdata <= (w_win == OWN_DM) ? dm_wdata : '0;
            r_wstrb <= (w_win == OWN_DM) ? dm_wstrb : '0;
            r_err   <= 1'b0;
        end else if (r_state == BUSY) begin
            if (mem_ready) begin
                r_rdata <= r_we ? '0 : mem_rdata;
                r_err   <= 1'b0;
            end else if (w_expired) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end
        end
    end

    always_comb begin
        if_gnt    = 1'b0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        dm_gnt    = 1'b0;
        dm_rvalid = 1'b0;
        dm_rdata  = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        resp_err  = 1'b0;
        busy      = 1'b0;
        if (!rst) begin
            unique case (r_state)
                IDLE: begin
                    if_gnt = if_req && (w_win == OWN_IF);
                    dm_gnt = dm_req && (w_win == OWN_DM);
                end
                BUSY: begin
                    mem_req   = 1'b1;
                    mem_we    = r_we;
                    mem_addr  = r_addr;
                    mem_wdata = r_wdata;
                    mem_wstrb = r_wstrb;
                    busy      = 1'b1;
                end
                RESP: begin
                    if (r_owner == OWN_DM) begin
                        dm_rvalid = 1'b1;
                        dm_rdata  = r_rdata;
                    end else begin
                        if_rvalid = 1'b1;
                        if_rdata  = r_rdata;
                    end
                    resp_err = r_err;
                    busy     = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
